// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory responder slice.
//   IDX_W / DATA_W : word-index width on the request ports and data word width
//   dmem_state_t   : responder FSM encoding (ST_IDLE, ST_BUSY_LD, ST_BUSY_ST)
//   merge_masked   : per-bit merge of new data into an existing word

package dmem_pkg;

    localparam int IDX_W  = 19;
    localparam int DATA_W = 64;

    // The FSM encoding is kept as plain constants so older blocks that
    // compare raw state bits keep working.
    typedef logic [1:0] dmem_state_t;

    localparam dmem_state_t ST_IDLE    = 2'd0;
    localparam dmem_state_t ST_BUSY_LD = 2'd1;
    localparam dmem_state_t ST_BUSY_ST = 2'd2;

    // Bits set in mask take the new value, cleared bits keep the old one.
    function automatic logic [DATA_W-1:0] merge_masked(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [DATA_W-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Single-port storage of 2^ADDR_W x DATA_W words with a synchronous,
// bit-masked write and a combinational read of the same address.
//   clock      : write clock
//   write_en   : commit the masked write at the rising edge
//   addr       : word address shared by read and write
//   write_mask : per-bit write enable
//   write_data : data merged under write_mask
//   read_data  : current contents of mem[addr]

module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_mask,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    // Contents are deliberately not reset so they survive an aborted request.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[addr] <= merge_masked(mem[addr], write_data, write_mask);
        end
    end

    assign read_data = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Services one load or store at a time against an internal dmem_array,
// completing each request a fixed LATENCY cycles after its handshake.
//   clock, reset_n                 : clock and synchronous active-low reset
//   opload_index_valid/_ready      : load request handshake
//   opload_index                   : load word index (low ADDR_W bits used)
//   opload_read_data               : load result, held until the next load
//   opload_operation_done          : one-cycle load completion pulse
//   opstore_index_valid/_ready     : store request handshake
//   opstore_index                  : store word index (low ADDR_W bits used)
//   opstore_write_mask/_write_data : per-bit mask and data of the store
//   opstore_operation_done         : one-cycle store completion pulse

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              opload_index_valid,
    input  logic [IDX_W-1:0]  opload_index,
    output logic              opload_index_ready,
    output logic [DATA_W-1:0] opload_read_data,
    output logic              opload_operation_done,
    input  logic              opstore_index_valid,
    input  logic [IDX_W-1:0]  opstore_index,
    output logic              opstore_index_ready,
    input  logic [DATA_W-1:0] opstore_write_mask,
    input  logic [DATA_W-1:0] opstore_write_data,
    output logic              opstore_operation_done
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t       state;
    logic [3:0]        count;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] held_data;
    logic [DATA_W-1:0] array_rdata;
    logic              st_hs;
    logic              ld_hs;
    logic              last_busy;

    // Index bits above ADDR_W alias onto the same entries and are dropped.
    logic unused_index_bits;
    assign unused_index_bits = ^{opload_index[IDX_W-1:ADDR_W],
                                 opstore_index[IDX_W-1:ADDR_W]};

    // Stores win a simultaneous request, so the load ready drops whenever a
    // store is being offered.
    assign opstore_index_ready = (state == ST_IDLE);
    assign opload_index_ready  = (state == ST_IDLE) & ~opstore_index_valid;

    assign st_hs = opstore_index_valid & opstore_index_ready;
    assign ld_hs = opload_index_valid & opload_index_ready;

    // The final busy cycle is the completion cycle. Gating with reset_n
    // makes a reset in that cycle abort the request (no pulse, no write).
    assign last_busy              = (count == 4'd0) & reset_n;
    assign opstore_operation_done = (state == ST_BUSY_ST) & last_busy;
    assign opload_operation_done  = (state == ST_BUSY_LD) & last_busy;

    // During the load completion cycle the array output is shown directly,
    // afterwards the captured copy keeps it stable.
    assign opload_read_data = opload_operation_done ? array_rdata : held_data;

    // Control state: FSM, latency counter and the held load result.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= 4'd0;
            held_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (st_hs) begin
                        state <= ST_BUSY_ST;
                        count <= LAT_M1;
                    end else if (ld_hs) begin
                        state <= ST_BUSY_LD;
                        count <= LAT_M1;
                    end
                end
                ST_BUSY_LD, ST_BUSY_ST: begin
                    if (count == 4'd0) begin
                        state <= ST_IDLE;
                        if (state == ST_BUSY_LD) begin
                            held_data <= array_rdata;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    // Request operands are captured only at the handshake so later changes
    // on the input ports cannot disturb an in-flight request.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE) begin
            if (st_hs) begin
                idx_q  <= opstore_index[ADDR_W-1:0];
                mask_q <= opstore_write_mask;
                data_q <= opstore_write_data;
            end else if (ld_hs) begin
                idx_q <= opload_index[ADDR_W-1:0];
            end
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock      (clock),
        .write_en   (opstore_operation_done),
        .addr       (idx_q),
        .write_mask (mask_q),
        .write_data (data_q),
        .read_data  (array_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Cycle-by-cycle directed vectors for dmem_responder (ADDR_W=10, LATENCY=2)
// followed by a hand-written reset-abort sequence.

module tb_dmem_responder;
    import dmem_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              opload_index_valid;
    logic [IDX_W-1:0]  opload_index;
    logic              opload_index_ready;
    logic [DATA_W-1:0] opload_read_data;
    logic              opload_operation_done;
    logic              opstore_index_valid;
    logic [IDX_W-1:0]  opstore_index;
    logic              opstore_index_ready;
    logic [DATA_W-1:0] opstore_write_mask;
    logic [DATA_W-1:0] opstore_write_data;
    logic              opstore_operation_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic              st_v;
        logic [IDX_W-1:0]  st_idx;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic              ld_v;
        logic [IDX_W-1:0]  ld_idx;
        logic              exp_st_rdy;
        logic              exp_ld_rdy;
        logic              exp_st_done;
        logic              exp_ld_done;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] JUNK = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] D1   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D2   = 64'h1122_3344_BBBB_BBBB;
    localparam logic [63:0] D3   = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D4   = 64'h0BAD_F00D_CAFE_BABE;
    localparam logic [63:0] D7   = 64'h7777_7777_7777_7777;

    dmem_responder #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .opload_index_valid     (opload_index_valid),
        .opload_index           (opload_index),
        .opload_index_ready     (opload_index_ready),
        .opload_read_data       (opload_read_data),
        .opload_operation_done  (opload_operation_done),
        .opstore_index_valid    (opstore_index_valid),
        .opstore_index          (opstore_index),
        .opstore_index_ready    (opstore_index_ready),
        .opstore_write_mask     (opstore_write_mask),
        .opstore_write_data     (opstore_write_data),
        .opstore_operation_done (opstore_operation_done)
    );

    always #5 clock = ~clock;

    function automatic vec_t vec(
        input logic st_v, input logic [IDX_W-1:0] st_idx,
        input logic [DATA_W-1:0] mask, input logic [DATA_W-1:0] data,
        input logic ld_v, input logic [IDX_W-1:0] ld_idx,
        input logic e_st_rdy, input logic e_ld_rdy,
        input logic e_st_done, input logic e_ld_done,
        input logic [DATA_W-1:0] e_rd
    );
        vec_t v;
        v.st_v = st_v;         v.st_idx = st_idx;
        v.mask = mask;         v.data = data;
        v.ld_v = ld_v;         v.ld_idx = ld_idx;
        v.exp_st_rdy = e_st_rdy;   v.exp_ld_rdy = e_ld_rdy;
        v.exp_st_done = e_st_done; v.exp_ld_done = e_ld_done;
        v.exp_rd = e_rd;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        opstore_index_valid = v.st_v;
        opstore_index       = v.st_idx;
        opstore_write_mask  = v.mask;
        opstore_write_data  = v.data;
        opload_index_valid  = v.ld_v;
        opload_index        = v.ld_idx;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        #1;
        check_val({tag, ".st_ready"}, 64'(opstore_index_ready), 64'(v.exp_st_rdy));
        check_val({tag, ".ld_ready"}, 64'(opload_index_ready), 64'(v.exp_ld_rdy));
        check_val({tag, ".st_done"}, 64'(opstore_operation_done), 64'(v.exp_st_done));
        check_val({tag, ".ld_done"}, 64'(opload_operation_done), 64'(v.exp_ld_done));
        check_val({tag, ".read_data"}, opload_read_data, v.exp_rd);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = vec(0, 19'h0, 64'h0, 64'h0, 0, 19'h0, 1, 1, 0, 0, 64'h0);

        // Store idx 5 full mask, then load it back (T -> done at T+2).
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 1, 1, 0, 0, 64'h0));
        vecs.push_back(vec(1, 19'h5,   ONES,  D1,    0, 19'h0, 1, 0, 0, 0, 64'h0));
        vecs.push_back(vec(0, 19'h0,   64'h0, JUNK,  0, 19'h0, 0, 0, 0, 0, 64'h0));
        vecs.push_back(vec(0, 19'h0,   64'h0, JUNK,  0, 19'h0, 0, 0, 1, 0, 64'h0));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 1, 19'h5, 1, 1, 0, 0, 64'h0));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, 64'h0));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D1));
        // Partial-mask store over idx 5, then reload.
        vecs.push_back(vec(1, 19'h5, 64'h0000_0000_FFFF_FFFF, 64'hAAAA_AAAA_BBBB_BBBB,
                           0, 19'h0, 1, 0, 0, 0, D1));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D1));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 1, 0, D1));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 1, 19'h5, 1, 1, 0, 0, D1));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D1));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D2));
        // Simultaneous store idx 9 and load idx 9: store first, load at T+3.
        vecs.push_back(vec(1, 19'h9,   ONES,  D3,    1, 19'h9, 1, 0, 0, 0, D2));
        vecs.push_back(vec(0, 19'h9,   ONES,  JUNK,  1, 19'h9, 0, 0, 0, 0, D2));
        vecs.push_back(vec(0, 19'h9,   ONES,  JUNK,  1, 19'h9, 0, 0, 1, 0, D2));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 1, 19'h9, 1, 1, 0, 0, D2));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D2));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D3));
        // Aliasing: store 0x00405, offer junk requests while busy, load 0x00005.
        vecs.push_back(vec(1, 19'h405, ONES,  D4,    0, 19'h0, 1, 0, 0, 0, D3));
        vecs.push_back(vec(1, 19'h3,   ONES,  JUNK,  1, 19'h3, 0, 0, 0, 0, D3));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 1, 0, D3));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 1, 19'h5, 1, 1, 0, 0, D3));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D3));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D4));
        // Zero mask still pulses done and leaves idx 5 (D2 via 0x405? no: D4).
        vecs.push_back(vec(1, 19'h5,   64'h0, ONES,  0, 19'h0, 1, 0, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 1, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 1, 19'h5, 1, 1, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D4));
        // Seed idx 7 for the reset-abort sequence.
        vecs.push_back(vec(1, 19'h7,   ONES,  D7,    0, 19'h0, 1, 0, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D4));
        vecs.push_back(vec(0, 19'h0,   64'h0, 64'h0, 0, 19'h0, 0, 0, 1, 0, D4));

        // Reset state.
        reset_n = 1'b0;
        applyStimulus(idle);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset", idle);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            check_val($sformatf("vec%0d.one_done", i),
                      64'(opload_operation_done & opstore_operation_done), 64'h0);
            next_cycle();
        end

        // Store to idx 7 aborted by reset in its T+1 cycle.
        applyStimulus(vec(1, 19'h7, ONES, 64'h0, 0, 19'h0, 1, 0, 0, 0, D4));
        checkOutput("abort.T", vec(1, 19'h7, ONES, 64'h0, 0, 19'h0, 1, 0, 0, 0, D4));
        next_cycle();
        applyStimulus(idle);
        reset_n = 1'b0;
        checkOutput("abort.T1", vec(0, 19'h0, 64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, D4));
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("abort.idle%0d", k), idle);
            next_cycle();
        end
        applyStimulus(vec(0, 19'h0, 64'h0, 64'h0, 1, 19'h7, 1, 1, 0, 0, 64'h0));
        checkOutput("abort.ld", vec(0, 19'h0, 64'h0, 64'h0, 1, 19'h7, 1, 1, 0, 0, 64'h0));
        next_cycle();
        applyStimulus(idle);
        checkOutput("abort.ld1", vec(0, 19'h0, 64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 0, 64'h0));
        next_cycle();
        checkOutput("abort.ld2", vec(0, 19'h0, 64'h0, 64'h0, 0, 19'h0, 0, 0, 0, 1, D7));
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
